// File: rtl/asm_div16.sv
// asm_div16: 16-bit unsigned restoring divider, one quotient bit per cycle (IDLE/CALC/DONE).
// Define ASM_DIV_ZERO_CHECK_EN to short-circuit divide-by-zero straight to DONE with dbz=1.
module asm_div16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        dbz
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] r_q, r_d, q_q, q_d, dvs_q, dvs_d;
    logic [15:0] quot_q, quot_d, rem_q, rem_d;
    logic        dbz_q, dbz_d;
    logic [16:0] r_sh;
    logic [15:0] diff;
    logic        ge;
    // The partial remainder stays below the divisor, so 16 bits hold it between steps.
    always_comb begin
        r_sh    = {r_q, q_q[15]};
        ge      = r_sh >= {1'b0, dvs_q};
        diff    = r_sh[15:0] - dvs_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef ASM_DIV_ZERO_CHECK_EN
        dbz_d   = dbz_q;
`else
        dbz_d   = 1'b0;
`endif
        case (state_q)
            CALC: begin
                r_d   = ge ? diff : r_sh[15:0];
                q_d   = {q_q[14:0], ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    state_d = DONE;
                    quot_d  = q_d;
                    rem_d   = r_d;
                    dbz_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                if (start) begin
                    state_d = CALC;
                    dvs_d   = divisor;
                    q_d     = dividend;
                    r_d     = 16'd0;
                    cnt_d   = 5'd0;
`ifdef ASM_DIV_ZERO_CHECK_EN
                    if (divisor == 16'd0) begin
                        state_d = DONE;
                        quot_d  = 16'hFFFF;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end
`endif
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            r_q     <= 16'd0;
            q_q     <= 16'd0;
            dvs_q   <= 16'd0;
            quot_q  <= 16'd0;
            rem_q   <= 16'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign busy      = state_q == CALC;
    assign done      = state_q == DONE;
    assign dbz       = dbz_q;
endmodule

// File: tb/tb_asm_div16.sv
// tb_asm_div16: randomized self-checking bench for asm_div16 against an arithmetic reference.
module tb_asm_div16;
`ifdef ASM_DIV_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] dividend, divisor, quotient, remainder;
    logic        busy, done, dbz;
    int          checks = 0, errors = 0, cyc = 0, last_done = 0;

    asm_div16 dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .dbz(dbz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit hold);
        logic [15:0] eq, er, pq, pr;
        bit          edbz, held;
        int          k, nb, ek;
        eq   = (b == 16'd0) ? 16'hFFFF : a / b;
        er   = (b == 16'd0) ? a : a % b;
        edbz = ZC && (b == 16'd0);
        ek   = edbz ? 0 : 16;
        pq   = quotient;
        pr   = remainder;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        k    = 0;
        nb   = 0;
        held = 1'b1;
        while (!done && k < 40) begin
            if (busy) nb++;
            if (quotient !== pq || remainder !== pr) held = 1'b0;
            start    = hold;
            dividend = 16'($urandom);
            divisor  = 16'($urandom);
            tick();
            k++;
        end
        start = 1'b0;
        last_done = cyc;
        check("latency", 32'(k), 32'(ek));
        check("busy_cycles", 32'(nb), 32'(ek));
        check("held_during_calc", 32'(held), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("dbz", 32'(dbz), 32'(edbz));
    endtask

    task automatic idle_pulse();
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    logic [15:0] da [6] = '{16'd100, 16'hFFFF, 16'hFFFF, 16'd5, 16'd0, 16'h1234};
    logic [15:0] db [6] = '{16'd7,   16'd1,    16'hFFFF, 16'd9, 16'd3, 16'd0};

    initial begin
        int t0;
        bit seen;
        logic [15:0] a, b;
        rst = 1'b1; start = 1'b1; dividend = 16'd50; divisor = 16'd3;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(dbz), 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            run_op(da[i], db[i], 1'b0);
            idle_pulse();
        end
        run_op(16'd1000, 16'd13, 1'b1);
        idle_pulse();
        run_op(16'd40000, 16'd123, 1'b0);
        t0 = last_done;
        run_op(16'd777, 16'd5, 1'b0);
        check("b2b_gap", 32'(last_done - t0), 32'd17);
        idle_pulse();
        start = 1'b1; dividend = 16'd9999; divisor = 16'd11;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_q", 32'(quotient), 32'd0);
        check("abort_r", 32'(remainder), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen |= done;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        run_op(16'd9999, 16'd11, 1'b0);
        idle_pulse();
        for (int i = 0; i < 2000; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 16'd0;
                1:       b = 16'($urandom_range(1, 15));
                default: b = 16'($urandom);
            endcase
            run_op(a, b, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) idle_pulse();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
